// File: rtl/thermal_framebuffer.sv
// Ping-pong BRAM framebuffer: the sensor writer fills one bank while the display reads the other.
// The display side upscales the frame into a raster window and maps pixel values through a palette.
module thermal_framebuffer #(
  parameter int          p_src_w       = 32,
  parameter int          p_src_h       = 24,
  parameter int          p_data_w      = 8,
  parameter int          p_scale       = 16,
  parameter int          p_x_off       = 64,
  parameter int          p_y_off       = 48,
  parameter int          p_count_width = 16,
  parameter logic [23:0] p_bg          = 24'h000000
) (
  input  logic                            i_clk_pixel,
  input  logic                            i_rst,
  input  logic                            i_frame,
  input  logic signed [p_count_width-1:0] i_x_pos,
  input  logic signed [p_count_width-1:0] i_y_pos,
  input  logic [1:0]                      i_mode,
  input  logic                            i_wr_valid,
  input  logic [p_data_w-1:0]             i_wr_data,
  input  logic                            i_wr_last,
  output logic                            o_wr_ready,
  output logic                            o_wr_err,
  output logic                            o_swap,
  output logic                            o_de,
  output logic [2:0][7:0]                 o_data
);

  localparam int N     = p_src_w * p_src_h;
  localparam int AW    = (N > 1) ? $clog2(N) : 1;
  localparam int DEPTH = 2 * (2 ** AW);
  localparam int SW    = (p_scale > 1) ? $clog2(p_scale) : 1;
  localparam int XW    = $clog2(p_src_w + 1);
  localparam int YW    = $clog2(p_src_h + 1);

  localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);
  localparam logic [SW-1:0] SUB_MAX   = SW'(p_scale - 1);

  localparam logic signed [p_count_width-1:0] X0 = p_count_width'(p_x_off);
  localparam logic signed [p_count_width-1:0] X1 = p_count_width'(p_x_off + p_src_w * p_scale);
  localparam logic signed [p_count_width-1:0] Y0 = p_count_width'(p_y_off);
  localparam logic signed [p_count_width-1:0] Y1 = p_count_width'(p_y_off + p_src_h * p_scale);

  logic [p_data_w-1:0] mem [DEPTH];
  logic [p_data_w-1:0] mem_rd_q;

  logic          rd_bank_q, rd_bank_d;
  logic          pending_q, pending_d;
  logic          frame_valid_q, frame_valid_d;
  logic          wr_ready_q, wr_ready_d;
  logic          wr_err_q, wr_err_d;
  logic          swap_q, swap_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic          wr_fire;

  logic [XW-1:0] src_x_q, src_x_d;
  logic [SW-1:0] sub_x_q, sub_x_d;
  logic [YW-1:0] src_y_q, src_y_d;
  logic [SW-1:0] sub_y_q, sub_y_d;
  logic signed [p_count_width-1:0] prev_y_q, prev_y_d;
  logic          in_x, in_y;

  logic [AW:0]   rd_addr_q, rd_addr_d;
  logic          de1_q, de1_d, grid1_q, grid1_d;
  logic [1:0]    mode1_q, mode1_d;
  logic          de2_q, de2_d, grid2_q, grid2_d;
  logic [1:0]    mode2_q, mode2_d;

  logic [7:0]    pix_v, pix_r, pix_g, pix_b;

  // Write side: a completed frame parks in `pending` until the next display frame start swaps banks.
  always_comb begin
    wr_fire       = i_wr_valid & wr_ready_q;
    rd_bank_d     = rd_bank_q;
    pending_d     = pending_q;
    frame_valid_d = frame_valid_q;
    wr_addr_d     = wr_addr_q;
    wr_err_d      = 1'b0;
    swap_d        = 1'b0;
    if (i_frame && pending_q) begin
      rd_bank_d     = ~rd_bank_q;
      pending_d     = 1'b0;
      frame_valid_d = 1'b1;
      swap_d        = 1'b1;
    end
    if (wr_fire) begin
      if (i_wr_last && (wr_addr_q == LAST_ADDR)) begin
        pending_d = 1'b1;
        wr_addr_d = '0;
      end else if (i_wr_last || (wr_addr_q == LAST_ADDR)) begin
        wr_err_d  = 1'b1;
        wr_addr_d = '0;
      end else begin
        wr_addr_d = wr_addr_q + AW'(1);
      end
    end
    wr_ready_d = ~pending_d;
  end

  // Source coordinates assume x steps by one per cycle and y changes once per line.
  always_comb begin
    in_x     = (i_x_pos >= X0) && (i_x_pos < X1);
    in_y     = (i_y_pos >= Y0) && (i_y_pos < Y1);
    src_x_d  = src_x_q;
    sub_x_d  = sub_x_q;
    src_y_d  = src_y_q;
    sub_y_d  = sub_y_q;
    prev_y_d = i_y_pos;
    if (i_x_pos == X0) begin
      src_x_d = '0;
      sub_x_d = '0;
    end else if (in_x) begin
      if (sub_x_q == SUB_MAX) begin
        sub_x_d = '0;
        src_x_d = src_x_q + XW'(1);
      end else begin
        sub_x_d = sub_x_q + SW'(1);
      end
    end
    if (i_y_pos == Y0) begin
      src_y_d = '0;
      sub_y_d = '0;
    end else if (in_y && (i_y_pos != prev_y_q)) begin
      if (sub_y_q == SUB_MAX) begin
        sub_y_d = '0;
        src_y_d = src_y_q + YW'(1);
      end else begin
        sub_y_d = sub_y_q + SW'(1);
      end
    end
    rd_addr_d = {rd_bank_q, AW'(int'(src_y_d) * p_src_w + int'(src_x_d))};
    de1_d     = in_x && in_y && frame_valid_q;
    grid1_d   = (sub_x_d == '0) || (sub_y_d == '0);
    mode1_d   = i_mode;
    de2_d     = de1_q;
    grid2_d   = grid1_q;
    mode2_d   = mode1_q;
  end

  always_ff @(posedge i_clk_pixel) begin
    if (i_rst) begin
      rd_bank_q     <= 1'b0;
      pending_q     <= 1'b0;
      frame_valid_q <= 1'b0;
      wr_ready_q    <= 1'b0;
      wr_err_q      <= 1'b0;
      swap_q        <= 1'b0;
      wr_addr_q     <= '0;
      src_x_q       <= '0;
      sub_x_q       <= '0;
      src_y_q       <= '0;
      sub_y_q       <= '0;
      prev_y_q      <= '0;
      rd_addr_q     <= '0;
      de1_q         <= 1'b0;
      grid1_q       <= 1'b0;
      mode1_q       <= '0;
      de2_q         <= 1'b0;
      grid2_q       <= 1'b0;
      mode2_q       <= '0;
    end else begin
      rd_bank_q     <= rd_bank_d;
      pending_q     <= pending_d;
      frame_valid_q <= frame_valid_d;
      wr_ready_q    <= wr_ready_d;
      wr_err_q      <= wr_err_d;
      swap_q        <= swap_d;
      wr_addr_q     <= wr_addr_d;
      src_x_q       <= src_x_d;
      sub_x_q       <= sub_x_d;
      src_y_q       <= src_y_d;
      sub_y_q       <= sub_y_d;
      prev_y_q      <= prev_y_d;
      rd_addr_q     <= rd_addr_d;
      de1_q         <= de1_d;
      grid1_q       <= grid1_d;
      mode1_q       <= mode1_d;
      de2_q         <= de2_d;
      grid2_q       <= grid2_d;
      mode2_q       <= mode2_d;
    end
  end

  // Kept free of reset so the array and its read register map onto block RAM.
  always_ff @(posedge i_clk_pixel) begin
    if (wr_fire && !i_rst) begin
      mem[{~rd_bank_q, wr_addr_q}] <= i_wr_data;
    end
    mem_rd_q <= mem[rd_addr_q];
  end

  if (p_data_w >= 8) begin : g_norm_wide
    assign pix_v = mem_rd_q[p_data_w-1 -: 8];
  end else begin : g_norm_narrow
    assign pix_v = {mem_rd_q, {(8 - p_data_w){1'b0}}};
  end

  always_comb begin
    pix_r = pix_v;
    pix_g = pix_v;
    pix_b = pix_v;
    case (mode2_q)
      2'd1: begin
        if (!pix_v[7]) begin
          pix_r = 8'h00;
          pix_g = {pix_v[6:0], 1'b0};
          pix_b = ~{pix_v[6:0], 1'b0};
        end else begin
          pix_r = {pix_v[6:0], 1'b0};
          pix_g = ~{pix_v[6:0], 1'b0};
          pix_b = 8'h00;
        end
      end
      2'd2: begin
        if (grid2_q) begin
          pix_r = 8'hFF;
          pix_g = 8'hFF;
          pix_b = 8'hFF;
        end
      end
      default: ;
    endcase
    if (de2_q) begin
      o_data = {pix_b, pix_g, pix_r};
    end else begin
      o_data = {p_bg[7:0], p_bg[15:8], p_bg[23:16]};
    end
  end

  assign o_wr_ready = wr_ready_q;
  assign o_wr_err   = wr_err_q;
  assign o_swap     = swap_q;
  assign o_de       = de2_q;

endmodule

// File: tb/tb_thermal_framebuffer.sv
// Directed bench for thermal_framebuffer: 4x2 source, scale 2, window at origin, tinted background.
module tb_thermal_framebuffer;

  localparam logic [23:0] BG = 24'h102030;

  logic               clk = 1'b0;
  logic               rst;
  logic               frame_in;
  logic signed [15:0] x_pos, y_pos;
  logic [1:0]         mode_in;
  logic               wr_valid;
  logic [7:0]         wr_data;
  logic               wr_last;
  logic               wr_ready, wr_err, swap, de;
  logic [2:0][7:0]    data;

  int total = 0;
  int bad   = 0;

  logic [7:0]  fb [8];
  logic [23:0] cap_rgb [6][12];
  logic        cap_de  [6][12];

  always #5 clk = ~clk;

  thermal_framebuffer #(
    .p_src_w(4), .p_src_h(2), .p_data_w(8), .p_scale(2),
    .p_x_off(0), .p_y_off(0), .p_count_width(16), .p_bg(BG)
  ) dut (
    .i_clk_pixel(clk), .i_rst(rst), .i_frame(frame_in),
    .i_x_pos(x_pos), .i_y_pos(y_pos), .i_mode(mode_in),
    .i_wr_valid(wr_valid), .i_wr_data(wr_data), .i_wr_last(wr_last),
    .o_wr_ready(wr_ready), .o_wr_err(wr_err), .o_swap(swap),
    .o_de(de), .o_data(data)
  );

  function automatic logic exp_de(input int x, input int y, input bit valid);
    return valid && x >= 0 && x < 8 && y >= 0 && y < 4;
  endfunction

  function automatic logic [23:0] exp_pix(input int x, input int y, input logic [1:0] mode, input bit valid);
    int v;
    logic [7:0] r, g, b;
    if (!exp_de(x, y, valid)) return BG;
    v = int'(fb[(y / 2) * 4 + x / 2]);
    r = 8'(v); g = 8'(v); b = 8'(v);
    if (mode == 2'd1) begin
      if (v < 128) begin
        r = 8'd0; g = 8'(2 * v); b = 8'(255 - 2 * v);
      end else begin
        r = 8'(2 * (v - 128)); g = 8'(255 - 2 * (v - 128)); b = 8'd0;
      end
    end else if (mode == 2'd2 && (x % 2 == 0 || y % 2 == 0)) begin
      r = 8'hFF; g = 8'hFF; b = 8'hFF;
    end
    return {r, g, b};
  endfunction

  // Called on a falling edge; returns on the falling edge just after the transfer.
  task automatic write_pixel(input logic [7:0] d, input logic lst);
    int guard = 0;
    wr_valid = 1'b1; wr_data = d; wr_last = lst;
    while (!wr_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!wr_ready) begin
      total++; bad++;
      $display("[TB] FAIL write_timeout got ready=%b want 1", wr_ready);
    end
    @(negedge clk);
    wr_valid = 1'b0; wr_last = 1'b0;
  endtask

  task automatic write_frame(input int base, input int len, input int last_at);
    for (int i = 0; i < len; i++) write_pixel(8'(base + i), i == last_at);
  endtask

  task automatic pulse_frame();
    frame_in = 1'b1;
    @(negedge clk);
    frame_in = 1'b0;
  endtask

  task automatic set_fb(input int base);
    for (int i = 0; i < 8; i++) fb[i] = 8'(base + i);
  endtask

  // Raster x=-2..9, y=-1..4; output for the pixel driven two falling edges earlier is captured.
  task automatic run_raster(input logic [1:0] mode);
    mode_in = mode;
    for (int k = 0; k < 74; k++) begin
      if (k >= 2) begin
        cap_rgb[(k - 2) / 12][(k - 2) % 12] = {data[0], data[1], data[2]};
        cap_de[(k - 2) / 12][(k - 2) % 12]  = de;
      end
      if (k < 72) begin
        x_pos = 16'((k % 12) - 2);
        y_pos = 16'((k / 12) - 1);
      end else begin
        x_pos = -16'sd100;
        y_pos = -16'sd100;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (wr_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_ready got %b want 0", wr_ready); end
    total++; if (wr_err !== 1'b0) begin bad++; $display("[TB] FAIL rst_err got %b want 0", wr_err); end
    total++; if (swap !== 1'b0) begin bad++; $display("[TB] FAIL rst_swap got %b want 0", swap); end
    total++; if (de !== 1'b0) begin bad++; $display("[TB] FAIL rst_de got %b want 0", de); end
    total++; if ({data[0], data[1], data[2]} !== BG) begin bad++; $display("[TB] FAIL rst_data got %h want %h", {data[0], data[1], data[2]}, BG); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (wr_ready !== 1'b1) begin bad++; $display("[TB] FAIL post_rst_ready got %b want 1", wr_ready); end
  endtask

  task automatic test_blank();
    pulse_frame();
    total++; if (swap !== 1'b0) begin bad++; $display("[TB] FAIL blank_swap got %b want 0", swap); end
    run_raster(2'd0);
    for (int r = 0; r < 6; r++) for (int c = 0; c < 12; c++) begin
      total++;
      if (cap_rgb[r][c] !== BG || cap_de[r][c] !== 1'b0) begin
        bad++; $display("[TB] FAIL blank_pix x=%0d y=%0d got de=%b rgb=%h want de=0 rgb=%h", c - 2, r - 1, cap_de[r][c], cap_rgb[r][c], BG);
      end
    end
  endtask

  task automatic test_basic_frame();
    write_frame(0, 8, 7);
    total++; if (wr_ready !== 1'b0) begin bad++; $display("[TB] FAIL basic_stall got ready=%b want 0", wr_ready); end
    total++; if (wr_err !== 1'b0) begin bad++; $display("[TB] FAIL basic_err got %b want 0", wr_err); end
    pulse_frame();
    total++; if (swap !== 1'b1) begin bad++; $display("[TB] FAIL basic_swap got %b want 1", swap); end
    @(negedge clk);
    total++; if (swap !== 1'b0) begin bad++; $display("[TB] FAIL basic_swap_end got %b want 0", swap); end
    total++; if (wr_ready !== 1'b1) begin bad++; $display("[TB] FAIL basic_ready got %b want 1", wr_ready); end
    set_fb(0);
    run_raster(2'd0);
    for (int r = 0; r < 6; r++) for (int c = 0; c < 12; c++) begin
      total++;
      if (cap_rgb[r][c] !== exp_pix(c - 2, r - 1, 2'd0, 1'b1) || cap_de[r][c] !== exp_de(c - 2, r - 1, 1'b1)) begin
        bad++; $display("[TB] FAIL basic_pix x=%0d y=%0d got de=%b rgb=%h want de=%b rgb=%h", c - 2, r - 1, cap_de[r][c], cap_rgb[r][c], exp_de(c - 2, r - 1, 1'b1), exp_pix(c - 2, r - 1, 2'd0, 1'b1));
      end
    end
  endtask

  task automatic test_back_to_back();
    write_frame(10, 8, 7);
    total++; if (wr_ready !== 1'b0) begin bad++; $display("[TB] FAIL b2b_stall got ready=%b want 0", wr_ready); end
    fork
      write_frame(50, 8, 7);
      begin
        repeat (5) @(negedge clk);
        total++; if (wr_ready !== 1'b0) begin bad++; $display("[TB] FAIL b2b_held got ready=%b want 0", wr_ready); end
        pulse_frame();
        total++; if (swap !== 1'b1) begin bad++; $display("[TB] FAIL b2b_swap got %b want 1", swap); end
      end
    join
    set_fb(10);
    run_raster(2'd0);
    for (int r = 0; r < 6; r++) for (int c = 0; c < 12; c++) begin
      total++;
      if (cap_rgb[r][c] !== exp_pix(c - 2, r - 1, 2'd0, 1'b1)) begin
        bad++; $display("[TB] FAIL b2b_a_pix x=%0d y=%0d got rgb=%h want rgb=%h", c - 2, r - 1, cap_rgb[r][c], exp_pix(c - 2, r - 1, 2'd0, 1'b1));
      end
    end
    pulse_frame();
    total++; if (swap !== 1'b1) begin bad++; $display("[TB] FAIL b2b_swap_b got %b want 1", swap); end
    set_fb(50);
    run_raster(2'd0);
    for (int r = 0; r < 6; r++) for (int c = 0; c < 12; c++) begin
      total++;
      if (cap_rgb[r][c] !== exp_pix(c - 2, r - 1, 2'd0, 1'b1)) begin
        bad++; $display("[TB] FAIL b2b_b_pix x=%0d y=%0d got rgb=%h want rgb=%h", c - 2, r - 1, cap_rgb[r][c], exp_pix(c - 2, r - 1, 2'd0, 1'b1));
      end
    end
  endtask

  task automatic test_len_err();
    write_frame(90, 6, 5);
    total++; if (wr_err !== 1'b1) begin bad++; $display("[TB] FAIL err_early_last got %b want 1", wr_err); end
    @(negedge clk);
    total++; if (wr_err !== 1'b0) begin bad++; $display("[TB] FAIL err_pulse_end got %b want 0", wr_err); end
    total++; if (wr_ready !== 1'b1) begin bad++; $display("[TB] FAIL err_ready got %b want 1", wr_ready); end
    pulse_frame();
    total++; if (swap !== 1'b0) begin bad++; $display("[TB] FAIL err_no_swap got %b want 0", swap); end
    write_frame(70, 8, -1);
    total++; if (wr_err !== 1'b1) begin bad++; $display("[TB] FAIL err_missing_last got %b want 1", wr_err); end
    write_frame(100, 7, -1);
    total++; if (wr_err !== 1'b0) begin bad++; $display("[TB] FAIL err_clean got %b want 0", wr_err); end
    frame_in = 1'b1;
    write_pixel(8'd107, 1'b1);
    frame_in = 1'b0;
    total++; if (swap !== 1'b0) begin bad++; $display("[TB] FAIL coincident_swap got %b want 0", swap); end
    total++; if (wr_ready !== 1'b0) begin bad++; $display("[TB] FAIL coincident_ready got %b want 0", wr_ready); end
    pulse_frame();
    total++; if (swap !== 1'b1) begin bad++; $display("[TB] FAIL deferred_swap got %b want 1", swap); end
    set_fb(100);
    run_raster(2'd3);
    for (int r = 0; r < 6; r++) for (int c = 0; c < 12; c++) begin
      total++;
      if (cap_rgb[r][c] !== exp_pix(c - 2, r - 1, 2'd3, 1'b1)) begin
        bad++; $display("[TB] FAIL err_good_pix x=%0d y=%0d got rgb=%h want rgb=%h", c - 2, r - 1, cap_rgb[r][c], exp_pix(c - 2, r - 1, 2'd3, 1'b1));
      end
    end
  endtask

  task automatic test_mode1();
    write_pixel(8'd0, 1'b0);
    write_pixel(8'd127, 1'b0);
    write_pixel(8'd128, 1'b0);
    write_pixel(8'd255, 1'b0);
    for (int i = 0; i < 4; i++) write_pixel(8'd0, i == 3);
    pulse_frame();
    total++; if (swap !== 1'b1) begin bad++; $display("[TB] FAIL m1_swap got %b want 1", swap); end
    fb[0] = 8'd0; fb[1] = 8'd127; fb[2] = 8'd128; fb[3] = 8'd255;
    for (int i = 4; i < 8; i++) fb[i] = 8'd0;
    run_raster(2'd1);
    total++; if (cap_rgb[1][2] !== 24'h0000FF) begin bad++; $display("[TB] FAIL m1_v0 got %h want 0000ff", cap_rgb[1][2]); end
    total++; if (cap_rgb[1][4] !== 24'h00FE01) begin bad++; $display("[TB] FAIL m1_v127 got %h want 00fe01", cap_rgb[1][4]); end
    total++; if (cap_rgb[1][6] !== 24'h00FF00) begin bad++; $display("[TB] FAIL m1_v128 got %h want 00ff00", cap_rgb[1][6]); end
    total++; if (cap_rgb[1][8] !== 24'hFE0100) begin bad++; $display("[TB] FAIL m1_v255 got %h want fe0100", cap_rgb[1][8]); end
    for (int r = 0; r < 6; r++) for (int c = 0; c < 12; c++) begin
      total++;
      if (cap_rgb[r][c] !== exp_pix(c - 2, r - 1, 2'd1, 1'b1)) begin
        bad++; $display("[TB] FAIL m1_pix x=%0d y=%0d got rgb=%h want rgb=%h", c - 2, r - 1, cap_rgb[r][c], exp_pix(c - 2, r - 1, 2'd1, 1'b1));
      end
    end
  endtask

  task automatic test_mode2_grid();
    run_raster(2'd2);
    total++; if (cap_rgb[1][1] !== BG || cap_de[1][1] !== 1'b0) begin bad++; $display("[TB] FAIL m2_left_edge got de=%b rgb=%h want de=0 rgb=%h", cap_de[1][1], cap_rgb[1][1], BG); end
    total++; if (cap_rgb[1][10] !== BG || cap_de[1][10] !== 1'b0) begin bad++; $display("[TB] FAIL m2_right_edge got de=%b rgb=%h want de=0 rgb=%h", cap_de[1][10], cap_rgb[1][10], BG); end
    total++; if (cap_rgb[2][2] !== 24'hFFFFFF) begin bad++; $display("[TB] FAIL m2_grid_x0y1 got %h want ffffff", cap_rgb[2][2]); end
    total++; if (cap_rgb[2][5] !== 24'h7F7F7F) begin bad++; $display("[TB] FAIL m2_fill_x3y1 got %h want 7f7f7f", cap_rgb[2][5]); end
    for (int r = 0; r < 6; r++) for (int c = 0; c < 12; c++) begin
      total++;
      if (cap_rgb[r][c] !== exp_pix(c - 2, r - 1, 2'd2, 1'b1) || cap_de[r][c] !== exp_de(c - 2, r - 1, 1'b1)) begin
        bad++; $display("[TB] FAIL m2_pix x=%0d y=%0d got de=%b rgb=%h want de=%b rgb=%h", c - 2, r - 1, cap_de[r][c], cap_rgb[r][c], exp_de(c - 2, r - 1, 1'b1), exp_pix(c - 2, r - 1, 2'd2, 1'b1));
      end
    end
  endtask

  task automatic test_reset_mid();
    write_frame(30, 3, -1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_raster(2'd0);
    for (int r = 0; r < 6; r++) for (int c = 0; c < 12; c++) begin
      total++;
      if (cap_rgb[r][c] !== BG || cap_de[r][c] !== 1'b0) begin
        bad++; $display("[TB] FAIL rmid_blank x=%0d y=%0d got de=%b rgb=%h want de=0 rgb=%h", c - 2, r - 1, cap_de[r][c], cap_rgb[r][c], BG);
      end
    end
    write_frame(200, 8, 7);
    total++; if (wr_err !== 1'b0) begin bad++; $display("[TB] FAIL rmid_err got %b want 0", wr_err); end
    total++; if (wr_ready !== 1'b0) begin bad++; $display("[TB] FAIL rmid_pending got ready=%b want 0", wr_ready); end
    pulse_frame();
    total++; if (swap !== 1'b1) begin bad++; $display("[TB] FAIL rmid_swap got %b want 1", swap); end
    set_fb(200);
    run_raster(2'd0);
    for (int r = 0; r < 6; r++) for (int c = 0; c < 12; c++) begin
      total++;
      if (cap_rgb[r][c] !== exp_pix(c - 2, r - 1, 2'd0, 1'b1)) begin
        bad++; $display("[TB] FAIL rmid_pix x=%0d y=%0d got rgb=%h want rgb=%h", c - 2, r - 1, cap_rgb[r][c], exp_pix(c - 2, r - 1, 2'd0, 1'b1));
      end
    end
  endtask

  initial begin
    rst = 1'b1; frame_in = 1'b0; mode_in = 2'd0;
    x_pos = -16'sd100; y_pos = -16'sd100;
    wr_valid = 1'b0; wr_data = 8'd0; wr_last = 1'b0;
    @(negedge clk);
    test_reset();
    test_blank();
    test_basic_frame();
    test_back_to_back();
    test_len_err();
    test_mode1();
    test_mode2_grid();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog got timeout want finish total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/thermal_framebuffer.md
Name: thermal_framebuffer

Overview:
- Double-buffered (ping-pong) BRAM framebuffer for low-resolution thermal frames, e.g. a 32x24 sensor.
- The sensor-side writer fills one bank while the display reads the other.
- The display side upscales the frame by an integer factor into a window of the HDMI raster, then maps pixel values to RGB through a selectable palette.
- Sits between the sensor readout/calibration path and the HDMI encoder. It takes raster position and frame/line strobes from the video timing generator.

Parameters:
- p_src_w, 32, source frame width in pixels
- p_src_h, 24, source frame height in pixels
- p_data_w, 8, stored pixel width (1..16)
- p_scale, 16, integer upscale factor per axis (>=1)
- p_x_off, 64, window left edge in display pixels
- p_y_off, 48, window top edge in display lines
- p_count_width, 16, width of signed raster position inputs
- p_bg, 24'h000000, background RGB outside window or before first frame

Ports:
- i_clk_pixel  in  1  pixel clock, all logic
- i_rst  in  1  synchronous reset, active-high
- i_frame  in  1  one-cycle pulse at display frame start
- i_x_pos  in  p_count_width (signed)  current raster x
- i_y_pos  in  p_count_width (signed)  current raster y
- i_mode  in  2  palette: 0 gray, 1 false colour, 2 gray+grid, 3 gray
- i_wr_valid  in  1  write pixel valid
- i_wr_data  in  p_data_w  write pixel value, raster order
- i_wr_last  in  1  marks last pixel of source frame
- o_wr_ready  out  1  writer may transfer
- o_wr_err  out  1  one-cycle pulse on frame length mismatch
- o_swap  out  1  one-cycle pulse when display bank swaps
- o_de  out  1  output pixel is inside the drawn window
- o_data  out  8 x [3]  RGB, [0]=R [1]=G [2]=B

Behaviour:
- Reset: o_wr_ready=0 during reset, 1 from the first cycle after. Also cleared by reset: o_wr_err, o_swap, o_de, rd_bank, pending, frame_valid, wr_addr. o_data=p_bg.
- Write handshake: a transfer happens on i_wr_valid & o_wr_ready. Data goes to the write bank (always ~rd_bank) at wr_addr, which then increments.
- Frame completion is a transfer with i_wr_last=1 and wr_addr==p_src_w*p_src_h-1. It sets pending=1 and wr_addr=0.
- Length mismatch is i_wr_last at any other address, or a transfer at the last address without i_wr_last. On mismatch: pulse o_wr_err, wr_addr=0, pending unchanged, frame discarded.
- o_wr_ready = ~pending. The writer stalls after a completed frame until the swap.
- Swap: on i_frame with pending=1 (registered value), set rd_bank<=~rd_bank, pending<=0, frame_valid<=1, and pulse o_swap the next cycle.
- If completion and i_frame coincide, the swap occurs at the following i_frame.
- Read window: x in [p_x_off, p_x_off+p_src_w*p_scale), y in [p_y_off, p_y_off+p_src_h*p_scale).
- Source coordinates come from column/row counters plus sub-counters 0..p_scale-1, loaded at window entry. No divider.
- Read address = src_y*p_src_w+src_x in rd_bank.
- Latency: o_data/o_de correspond to the i_x_pos/i_y_pos presented exactly 2 cycles earlier (1 address register + 1 BRAM read).
- o_de=1 only inside the window with frame_valid=1. Otherwise o_data=p_bg.
- Value normalisation: v = top 8 bits of data, or zero-extended left-aligned when p_data_w<8.
- Mode 0/3: R=G=B=v.
- Mode 1: if v<128 then R=0, G=2v, B=255-2v; else R=2(v-128), G=255-2(v-128), B=0.
- Mode 2: as mode 0, but pixels with sub-x==0 or sub-y==0 output 8'hFF on all channels.
- i_mode is sampled in the address stage and pipelined with the pixel.
- Reset mid-write discards the partial frame. Reset mid-display returns to background until the next completed frame and swap.

Test Plan:
- p_src_w=4, p_src_h=2, p_scale=2, p_x_off=p_y_off=0: write 0..7 with last, pulse i_frame -> o_swap next cycle. Raster row 0 x=0..7 gives v=0,0,1,1,2,2,3,3 two cycles late. Rows 2..3 give 4..7.
- Before any write, sweep full raster -> o_de=0 and o_data=p_bg everywhere.
- Complete frame A, then stream frame B without i_frame -> o_wr_ready drops after A's last. B's first transfer stalls until the i_frame swap, then B lands in the other bank.
- i_wr_last at address 5 of 8 -> o_wr_err pulse, no swap on next i_frame, next full frame swaps normally.
- Mode 1 with v=0,127,128,255 -> RGB (0,0,255), (0,254,1), (0,255,0), (254,1,0).
- Mode 2, scale 2 -> every even display x and even y inside window outputs FF,FF,FF. Window edges at x=p_x_off-1 and x=p_x_off+p_src_w*p_scale give p_bg.
